// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller:
// hex-to-segment table, blanking values and the slot-state enum.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low g..a patterns with dp off (bit 7 high); entry n lives at [n].
  localparam logic [15:0][7:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } slot_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG_TABLE[nib][6:0];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex nibble to active-low g..a segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit common-anode scan controller with per-slot blanking,
// leading-zero suppression and a frame-aligned double-buffered display word.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_mask,
  input  logic        lz_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        pending,
  output logic        frame_done
);

  localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dig_q, dig_d;
  slot_state_e      state_q, state_d;
  logic [31:0]      act_data_q, act_data_d;
  logic [7:0]       act_dp_q, act_dp_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic [7:0]       pend_dp_q, pend_dp_d;
  logic             pending_q, pending_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic             slot_end;
  logic             frame_end;
  logic [3:0]       cur_nib;
  logic [6:0]       cur_seg;
  logic [7:0]       dark;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (dig_q == 3'd7);

  // Prescaler, digit index and slot state; state tracks the counter value it
  // will hold next so that state_q and cnt_q always describe the same cycle.
  always_comb begin
    cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
    dig_d        = slot_end ? dig_q + 3'd1 : dig_q;
    state_d      = (cnt_d < CNT_BLANK) ? BLANK : DRIVE;
    frame_done_d = (cnt_d == CNT_LAST) && (dig_d == 3'd7);
  end

  // A load coincident with a commit is kept pending; the commit uses the
  // value that was pending before this cycle.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    pending_d   = pending_q && !frame_end;
    if (frame_end && pending_q) begin
      act_data_d = pend_data_q;
      act_dp_d   = pend_dp_q;
    end
    if (load) begin
      pend_data_d = data_in;
      pend_dp_d   = dp_in;
      pending_d   = 1'b1;
    end
  end

  // Per-digit dark flags: masked off, or a leading zero when suppression is on.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dark
      if (gi == 0) begin : g_lsd
        assign dark[gi] = !en_mask[gi];
      end else begin : g_upper
        assign dark[gi] = !en_mask[gi] || (lz_en && (act_data_q[31:4*gi] == '0));
      end
    end
  endgenerate

  assign cur_nib = act_data_q[{dig_q, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nib   (cur_nib),
    .seg_n (cur_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if ((state_q == DRIVE) && !dark[dig_q]) begin
      an_d  = ~(8'd1 << dig_q);
      seg_d = {~act_dp_q[dig_q], cur_seg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dig_q        <= 3'd0;
      state_q      <= BLANK;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      state_q      <= state_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed scoreboard bench for seg7_scan_ctrl: expected per-cycle pin values
// are queued ahead of each frame and popped as the scan produces them.
module tb_seg7_scan_ctrl;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        load    = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in   = '0;
  logic [7:0]  en_mask = 8'hFF;
  logic        lz_en   = 1'b0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        pending;
  logic        frame_done;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic [7:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  seg7_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .en_mask    (en_mask),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  4'hF: return 8'h8E;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Queue the 64 pin values of one frame, slot by slot.
  task automatic push_frame(input logic [31:0] word, input logic [7:0] dp,
                            input logic [7:0] mask, input logic lz);
    exp_t       e;
    logic [3:0] nib;
    logic [7:0] pat;
    logic       is_dark;
    for (int k = 0; k < 8; k++) begin
      nib     = word[4*k +: 4];
      is_dark = !mask[k] || (lz && (k != 0) && ((word >> (4 * k)) == 32'd0));
      pat     = hex_seg(nib);
      for (int j = 0; j < SCAN_DIV; j++) begin
        e.idx = 8'(k * SCAN_DIV + j);
        if (j < BLANK_CYC || is_dark) begin
          e.an  = 8'hFF;
          e.seg = 8'hFF;
        end else begin
          e.an  = ~(8'd1 << k);
          e.seg = {~dp[k], pat[6:0]};
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    load = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("an[%0d]", e.idx), {24'd0, an}, {24'd0, e.an});
      chk($sformatf("seg[%0d]", e.idx), {24'd0, seg}, {24'd0, e.seg});
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    step();
  endtask

  // Returns just after the commit edge that ends the next frame_done cycle.
  task automatic wait_frame_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (frame_done === 1'b1) seen = 1'b1;
    end
    chk("frame_done_seen", {31'd0, seen}, 32'd1);
    if (seen) step();
  endtask

  task automatic run_frame(input logic [31:0] word, input logic [7:0] dp,
                           input logic [7:0] mask, input logic lz);
    push_frame(word, dp, mask, lz);
    repeat (SCAN_DIV * 8 - 1) step();
    chk("frame_done_hi", {31'd0, frame_done}, 32'd1);
    step();
    chk("frame_done_lo", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic push_restart();
    exp_t e;
    e = '{an: 8'hFF, seg: 8'hFF, idx: 8'd0};  exp_q.push_back(e);
    e = '{an: 8'hFF, seg: 8'hFF, idx: 8'd1};  exp_q.push_back(e);
    e = '{an: 8'hFE, seg: 8'hC0, idx: 8'd2};  exp_q.push_back(e);
  endtask

  initial begin
    // Reset state and first DRIVE slot
    #1 rst_n = 1'b0;
    #1;
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {24'd0, seg}, 32'hFF);
    chk("rst_pending", {31'd0, pending}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    #21 rst_n = 1'b1;
    push_restart();
    repeat (3) step();

    // Plain load, shown after the next commit
    do_load(32'h0123_4567, 8'h00);
    chk("pending_after_load", {31'd0, pending}, 32'd1);
    wait_frame_done();
    chk("pending_after_commit", {31'd0, pending}, 32'd0);
    run_frame(32'h0123_4567, 8'h00, 8'hFF, 1'b0);

    // Decimal point with lower digits masked
    en_mask = 8'hF0;
    do_load(32'hDEAD_BEEF, 8'h01);
    wait_frame_done();
    run_frame(32'hDEAD_BEEF, 8'h01, 8'hF0, 1'b0);

    // Leading-zero suppression
    en_mask = 8'hFF;
    lz_en   = 1'b1;
    do_load(32'h0000_00A0, 8'h00);
    wait_frame_done();
    run_frame(32'h0000_00A0, 8'h00, 8'hFF, 1'b1);
    do_load(32'h0000_0000, 8'h00);
    wait_frame_done();
    run_frame(32'h0000_0000, 8'h00, 8'hFF, 1'b1);

    // Two loads mid-frame: old word holds, only the second is shown
    push_frame(32'h0000_0000, 8'h00, 8'hFF, 1'b1);
    repeat (3) step();
    do_load(32'h1111_1111, 8'hFF);
    chk("pending_A", {31'd0, pending}, 32'd1);
    step();
    do_load(32'h2222_2222, 8'h00);
    repeat (57) step();
    chk("frame_done_AB", {31'd0, frame_done}, 32'd1);
    chk("pending_before_AB_commit", {31'd0, pending}, 32'd1);
    step();
    chk("pending_after_AB_commit", {31'd0, pending}, 32'd0);
    run_frame(32'h2222_2222, 8'h00, 8'hFF, 1'b1);

    // Load landing in the frame_done cycle itself
    push_frame(32'h2222_2222, 8'h00, 8'hFF, 1'b1);
    repeat (10) step();
    do_load(32'h3333_3333, 8'h0F);
    repeat (52) step();
    chk("frame_done_C", {31'd0, frame_done}, 32'd1);
    chk("pending_C", {31'd0, pending}, 32'd1);
    do_load(32'h4567_89AB, 8'hA5);
    chk("pending_D_kept", {31'd0, pending}, 32'd1);
    run_frame(32'h3333_3333, 8'h0F, 8'hFF, 1'b1);
    chk("pending_D_committed", {31'd0, pending}, 32'd0);
    run_frame(32'h4567_89AB, 8'hA5, 8'hFF, 1'b1);

    // Asynchronous reset during digit 3's DRIVE, with a load in flight
    repeat (28) step();
    chk("mid_an_dig3", {24'd0, an}, 32'hF7);
    data_in = 32'h8888_8888;
    load    = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("async_an", {24'd0, an}, 32'hFF);
    chk("async_seg", {24'd0, seg}, 32'hFF);
    chk("async_pending", {31'd0, pending}, 32'd0);
    chk("async_frame_done", {31'd0, frame_done}, 32'd0);
    load = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    push_restart();
    repeat (3) step();
    chk("restart_pending", {31'd0, pending}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
